// File: rtl/str_num_frame_ctrl.sv
// Byte-stream frame controller for the 4-digit ASCII-to-integer converter:
// collects digits into a right-justified zero-padded buffer, validates, converts, hands off.
module str_num_frame_ctrl #(
   parameter int unsigned MAX_DIGITS = 4,
   parameter logic [7:0]  TERM_CHAR  = 8'h0D
) (
   input  logic                    clk,
   input  logic                    reset,
   input  logic [7:0]              rx_data,
   input  logic                    rx_valid,
   output logic                    rx_ready,
   output logic [8*MAX_DIGITS-1:0] conv_buf,
   input  logic [8*MAX_DIGITS-1:0] conv_val,
   output logic [8*MAX_DIGITS-1:0] out_data,
   output logic                    out_valid,
   input  logic                    out_ready,
   output logic                    err
);

   localparam int unsigned BW = 8 * MAX_DIGITS;
   localparam int unsigned CW = $clog2(MAX_DIGITS + 1);
   localparam logic [BW-1:0] PAD = {MAX_DIGITS{8'h30}};

   typedef enum logic [2:0] {
      IDLE,
      COLLECT,
      DISCARD,
      CONVERT,
      OUT
   } state_t;

   state_t        state_q, state_d;
   logic [BW-1:0] buf_q, buf_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic [BW-1:0] out_data_q, out_data_d;
   logic          out_valid_q, out_valid_d;
   logic          err_q, err_d;

   logic accept, is_digit, is_term;

   assign rx_ready  = (state_q == IDLE) || (state_q == COLLECT) || (state_q == DISCARD);
   assign accept    = rx_valid && rx_ready;
   assign is_digit  = (rx_data >= 8'h30) && (rx_data <= 8'h39);
   assign is_term   = (rx_data == TERM_CHAR);
   assign conv_buf  = buf_q;
   assign out_data  = out_data_q;
   assign out_valid = out_valid_q;
   assign err       = err_q;

   always_comb begin
      state_d     = state_q;
      buf_d       = buf_q;
      cnt_d       = cnt_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      err_d       = 1'b0;
      case (state_q)
         IDLE: begin
            if (accept) begin
               if (is_digit) begin
                  buf_d   = {PAD[BW-9:0], rx_data};
                  cnt_d   = CW'(1);
                  state_d = COLLECT;
               end else if (!is_term) begin
                  state_d = DISCARD;
               end
            end
         end
         COLLECT: begin
            if (accept) begin
               if (is_term) begin
                  state_d = CONVERT;
               end else if (is_digit && (cnt_q < CW'(MAX_DIGITS))) begin
                  buf_d = {buf_q[BW-9:0], rx_data};
                  cnt_d = cnt_q + CW'(1);
               end else begin
                  state_d = DISCARD;
               end
            end
         end
         DISCARD: begin
            if (accept && is_term) begin
               err_d   = 1'b1;
               buf_d   = PAD;
               cnt_d   = '0;
               state_d = IDLE;
            end
         end
         CONVERT: begin
            out_data_d  = conv_val;
            out_valid_d = 1'b1;
            state_d     = OUT;
         end
         OUT: begin
            if (out_valid_q && out_ready) begin
               out_valid_d = 1'b0;
               buf_d       = PAD;
               cnt_d       = '0;
               state_d     = IDLE;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q     <= IDLE;
         buf_q       <= PAD;
         cnt_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
         err_q       <= 1'b0;
      end else begin
         state_q     <= state_d;
         buf_q       <= buf_d;
         cnt_q       <= cnt_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
         err_q       <= err_d;
      end
   end

endmodule

// File: tb/tb_str_num_frame_ctrl.sv
// Directed bench for str_num_frame_ctrl with a behavioural ASCII-to-integer converter.
module tb_str_num_frame_ctrl;

   logic        clk = 1'b0;
   logic        reset;
   logic [7:0]  rx_data;
   logic        rx_valid;
   logic        rx_ready;
   logic [31:0] conv_buf;
   logic [31:0] conv_val;
   logic [31:0] out_data;
   logic        out_valid;
   logic        out_ready;
   logic        err;

   int n_assert = 0;
   int n_fail   = 0;

   str_num_frame_ctrl #(.MAX_DIGITS(4), .TERM_CHAR(8'h0D)) dut (
      .clk(clk), .reset(reset),
      .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready),
      .conv_buf(conv_buf), .conv_val(conv_val),
      .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
      .err(err)
   );

   always #5 clk = ~clk;

   function automatic logic [31:0] conv_model(input logic [31:0] b);
      int unsigned acc = 0;
      int unsigned w   = 1;
      for (int i = 0; i < 4; i++) begin
         acc = acc + (int'(b[8*i +: 8]) - 48) * w;
         w   = w * 10;
      end
      return acc;
   endfunction

   always_comb conv_val = conv_model(conv_buf);

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_assert++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s: observed 'h%0h expected 'h%0h", tag, obs, exp);
      end
   endtask

   // Called #1 after a rising edge; returns #1 after the edge that consumed the byte.
   task automatic send(input logic [7:0] b);
      int waited = 0;
      rx_data  = b;
      rx_valid = 1'b1;
      while (!rx_ready && waited < 50) begin
         @(posedge clk); #1;
         waited++;
      end
      chk("rx_ready_wait", 32'(waited < 50), 32'd1);
      @(posedge clk); #1;
      rx_valid = 1'b0;
   endtask

   task automatic send_str(input string s);
      for (int i = 0; i < s.len(); i++) send(s[i]);
   endtask

   task automatic expect_result(input string tag, input logic [31:0] val);
      chk({tag, "_ov_convert"}, 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk({tag, "_ov"}, 32'(out_valid), 32'd1);
      chk({tag, "_data"}, out_data, val);
      @(posedge clk); #1;
      chk({tag, "_ov_drop"}, 32'(out_valid), 32'd0);
      chk({tag, "_rdy_back"}, 32'(rx_ready), 32'd1);
   endtask

   initial begin
      reset     = 1'b1;
      rx_data   = 8'h00;
      rx_valid  = 1'b0;
      out_ready = 1'b1;
      #2;
      chk("rst_buf", conv_buf, 32'h30303030);
      chk("rst_data", out_data, 32'd0);
      chk("rst_ov", 32'(out_valid), 32'd0);
      chk("rst_err", 32'(err), 32'd0);
      chk("rst_rdy", 32'(rx_ready), 32'd1);
      @(posedge clk); #1;
      reset = 1'b0;

      // full-width frame, single-cycle output with out_ready high
      send_str("1234");
      send(8'h0D);
      chk("f1234_buf", conv_buf, 32'h31323334);
      chk("f1234_rdy_low", 32'(rx_ready), 32'd0);
      expect_result("f1234", 32'd1234);

      send_str("7");
      send(8'h0D);
      chk("f7_buf", conv_buf, 32'h30303037);
      expect_result("f7", 32'd7);

      send_str("0");
      send(8'h0D);
      expect_result("f0", 32'd0);

      send_str("9999");
      send(8'h0D);
      expect_result("f9999", 32'd9999);

      // overlength frame
      send_str("12345");
      send(8'h0D);
      chk("ovl_err", 32'(err), 32'd1);
      chk("ovl_ov", 32'(out_valid), 32'd0);
      @(posedge clk); #1;
      chk("ovl_err_drop", 32'(err), 32'd0);
      chk("ovl_buf", conv_buf, 32'h30303030);
      chk("ovl_ov2", 32'(out_valid), 32'd0);
      send_str("56");
      send(8'h0D);
      expect_result("f56", 32'd56);

      // non-digit inside frame
      send_str("1a2");
      send(8'h0D);
      chk("bad_err", 32'(err), 32'd1);
      @(posedge clk); #1;
      chk("bad_err_drop", 32'(err), 32'd0);
      chk("bad_ov", 32'(out_valid), 32'd0);

      // lone terminator is ignored
      send(8'h0D);
      chk("lone_err", 32'(err), 32'd0);
      chk("lone_rdy", 32'(rx_ready), 32'd1);
      @(posedge clk); #1;
      chk("lone_ov", 32'(out_valid), 32'd0);
      chk("lone_err2", 32'(err), 32'd0);

      // backpressure: result held, next byte waits at the source
      out_ready = 1'b0;
      send_str("99");
      send(8'h0D);
      @(posedge clk); #1;
      rx_data  = 8'h35;
      rx_valid = 1'b1;
      for (int c = 0; c < 10; c++) begin
         chk("bp_ov", 32'(out_valid), 32'd1);
         chk("bp_data", out_data, 32'd99);
         chk("bp_rdy", 32'(rx_ready), 32'd0);
         @(posedge clk); #1;
      end
      chk("bp_buf_held", conv_buf, 32'h30303939);
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("bp_ov_drop", 32'(out_valid), 32'd0);
      chk("bp_rdy_back", 32'(rx_ready), 32'd1);
      chk("bp_buf_clr", conv_buf, 32'h30303030);
      @(posedge clk); #1;
      rx_valid = 1'b0;
      chk("bp_byte_taken", conv_buf, 32'h30303035);
      send(8'h0D);
      expect_result("f5", 32'd5);

      // asynchronous reset mid-frame
      send_str("12");
      chk("mid_buf", conv_buf, 32'h30303132);
      reset = 1'b1;
      #1;
      chk("mrst_buf", conv_buf, 32'h30303030);
      chk("mrst_data", out_data, 32'd0);
      chk("mrst_ov", 32'(out_valid), 32'd0);
      chk("mrst_err", 32'(err), 32'd0);
      chk("mrst_rdy", 32'(rx_ready), 32'd1);
      @(posedge clk); #1;
      reset = 1'b0;
      send_str("3");
      send(8'h0D);
      chk("f3_buf", conv_buf, 32'h30303033);
      expect_result("f3", 32'd3);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL global_timeout: observed running expected finished");
      $fatal(1, "timeout");
   end

endmodule
